// File: rtl/hpdcache_refill_unit.sv
// Refill unit: accepts a memory read burst for one MSHR entry, writes the line
// into the data array word by word, and returns the requested word to the core.
module hpdcache_refill_unit #(
    parameter int MSHR_SET_WIDTH = 4,
    parameter int MSHR_WAY_WIDTH = 2,
    parameter int LINE_WORDS     = 8,
    parameter int NLINE_WIDTH    = 26,
    parameter int TID_WIDTH      = 6,
    parameter int SID_WIDTH      = 3,
    localparam int WW            = $clog2(LINE_WORDS),
    localparam int ID_W          = MSHR_SET_WIDTH + MSHR_WAY_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mem_rsp_valid_i,
    output logic                      mem_rsp_ready_o,
    input  logic [ID_W-1:0]           mem_rsp_id_i,
    input  logic [63:0]               mem_rsp_data_i,
    input  logic                      mem_rsp_last_i,
    input  logic                      mem_rsp_error_i,
    input  logic                      mshr_ack_gnt_i,
    output logic                      mshr_ack_o,
    output logic [MSHR_SET_WIDTH-1:0] mshr_ack_set_o,
    output logic [MSHR_WAY_WIDTH-1:0] mshr_ack_way_o,
    input  logic [TID_WIDTH-1:0]      mshr_ack_req_id_i,
    input  logic [SID_WIDTH-1:0]      mshr_ack_src_id_i,
    input  logic [NLINE_WIDTH-1:0]    mshr_ack_nline_i,
    input  logic [WW-1:0]             mshr_ack_word_i,
    input  logic                      mshr_ack_need_rsp_i,
    input  logic                      mshr_ack_is_prefetch_i,
    output logic                      refill_write_o,
    output logic [NLINE_WIDTH-1:0]    refill_nline_o,
    output logic [WW-1:0]             refill_word_o,
    output logic [63:0]               refill_data_o,
    output logic                      refill_done_o,
    output logic                      core_rsp_valid_o,
    input  logic                      core_rsp_ready_i,
    output logic [TID_WIDTH-1:0]      core_rsp_tid_o,
    output logic [SID_WIDTH-1:0]      core_rsp_sid_o,
    output logic [63:0]               core_rsp_data_o,
    output logic                      core_rsp_error_o,
    output logic                      busy_o,
    output logic                      proto_err_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACK  = 3'd1;
    localparam logic [2:0] META = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] RSP  = 3'd4;

    localparam logic [WW-1:0] CNT_LAST = WW'(LINE_WORDS - 1);

    logic [2:0]             state_q;
    logic [ID_W-1:0]        id_q;
    logic [WW-1:0]          cnt_q;
    logic [WW-1:0]          word_q;
    logic                   err_q;
    logic                   proto_q;
    logic                   done_q;
    logic                   need_q;
    logic                   pref_q;
    logic [TID_WIDTH-1:0]   tid_q;
    logic [SID_WIDTH-1:0]   sid_q;
    logic [NLINE_WIDTH-1:0] nline_q;
    logic [63:0]            rdata_q;

    logic beat_acc;
    logic is_last;

    // Handshakes: a memory beat transfers on mem_rsp_valid_i & mem_rsp_ready_o,
    // a core response on core_rsp_valid_o & core_rsp_ready_i; valid never drops
    // before the transfer and the payload stays stable while waiting.
    assign beat_acc = (state_q == DATA) && mem_rsp_valid_i;
    assign is_last  = (cnt_q == CNT_LAST);

    assign mem_rsp_ready_o  = (state_q == DATA);
    assign mshr_ack_o       = (state_q == ACK) && mshr_ack_gnt_i;
    assign mshr_ack_set_o   = id_q[MSHR_SET_WIDTH-1:0];
    assign mshr_ack_way_o   = id_q[ID_W-1 -: MSHR_WAY_WIDTH];
    assign refill_write_o   = beat_acc;
    assign refill_nline_o   = nline_q;
    assign refill_word_o    = cnt_q;
    assign refill_data_o    = beat_acc ? mem_rsp_data_i : 64'd0;
    assign refill_done_o    = done_q;
    assign core_rsp_valid_o = (state_q == RSP);
    assign core_rsp_tid_o   = tid_q;
    assign core_rsp_sid_o   = sid_q;
    assign core_rsp_data_o  = rdata_q;
    assign core_rsp_error_o = err_q;
    assign busy_o           = (state_q != IDLE);
    assign proto_err_o      = proto_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            proto_q <= 1'b0;
            done_q  <= 1'b0;
            need_q  <= 1'b0;
            pref_q  <= 1'b0;
            tid_q   <= '0;
            sid_q   <= '0;
            nline_q <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_rsp_valid_i) begin
                        id_q    <= mem_rsp_id_i;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (mshr_ack_gnt_i) state_q <= META;
                end
                META: begin
                    // Entry fields arrive one cycle after the ack strobe
                    tid_q   <= mshr_ack_req_id_i;
                    sid_q   <= mshr_ack_src_id_i;
                    nline_q <= mshr_ack_nline_i;
                    word_q  <= mshr_ack_word_i;
                    need_q  <= mshr_ack_need_rsp_i;
                    pref_q  <= mshr_ack_is_prefetch_i;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= DATA;
                end
                DATA: begin
                    if (beat_acc) begin
                        cnt_q <= cnt_q + 1'b1;
                        err_q <= err_q | mem_rsp_error_i;
                        if (cnt_q == word_q) rdata_q <= mem_rsp_data_i;
                        // The beat count is authoritative; the memory marker is only checked
                        if (mem_rsp_last_i != is_last) proto_q <= 1'b1;
                        if (is_last) begin
                            done_q  <= 1'b1;
                            state_q <= (need_q && !pref_q) ? RSP : IDLE;
                        end
                    end
                end
                RSP: begin
                    if (core_rsp_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpdcache_refill_unit.sv
// Directed bench for hpdcache_refill_unit: drives whole refills step by step
// and checks every output against hand-derived values.
module tb_hpdcache_refill_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_rsp_valid_i;
    logic        mem_rsp_ready_o;
    logic [5:0]  mem_rsp_id_i;
    logic [63:0] mem_rsp_data_i;
    logic        mem_rsp_last_i;
    logic        mem_rsp_error_i;
    logic        mshr_ack_gnt_i;
    logic        mshr_ack_o;
    logic [3:0]  mshr_ack_set_o;
    logic [1:0]  mshr_ack_way_o;
    logic [5:0]  mshr_ack_req_id_i;
    logic [2:0]  mshr_ack_src_id_i;
    logic [25:0] mshr_ack_nline_i;
    logic [2:0]  mshr_ack_word_i;
    logic        mshr_ack_need_rsp_i;
    logic        mshr_ack_is_prefetch_i;
    logic        refill_write_o;
    logic [25:0] refill_nline_o;
    logic [2:0]  refill_word_o;
    logic [63:0] refill_data_o;
    logic        refill_done_o;
    logic        core_rsp_valid_o;
    logic        core_rsp_ready_i;
    logic [5:0]  core_rsp_tid_o;
    logic [2:0]  core_rsp_sid_o;
    logic [63:0] core_rsp_data_o;
    logic        core_rsp_error_o;
    logic        busy_o;
    logic        proto_err_o;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic exp_proto = 1'b0;

    hpdcache_refill_unit dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .mem_rsp_valid_i        (mem_rsp_valid_i),
        .mem_rsp_ready_o        (mem_rsp_ready_o),
        .mem_rsp_id_i           (mem_rsp_id_i),
        .mem_rsp_data_i         (mem_rsp_data_i),
        .mem_rsp_last_i         (mem_rsp_last_i),
        .mem_rsp_error_i        (mem_rsp_error_i),
        .mshr_ack_gnt_i         (mshr_ack_gnt_i),
        .mshr_ack_o             (mshr_ack_o),
        .mshr_ack_set_o         (mshr_ack_set_o),
        .mshr_ack_way_o         (mshr_ack_way_o),
        .mshr_ack_req_id_i      (mshr_ack_req_id_i),
        .mshr_ack_src_id_i      (mshr_ack_src_id_i),
        .mshr_ack_nline_i       (mshr_ack_nline_i),
        .mshr_ack_word_i        (mshr_ack_word_i),
        .mshr_ack_need_rsp_i    (mshr_ack_need_rsp_i),
        .mshr_ack_is_prefetch_i (mshr_ack_is_prefetch_i),
        .refill_write_o         (refill_write_o),
        .refill_nline_o         (refill_nline_o),
        .refill_word_o          (refill_word_o),
        .refill_data_o          (refill_data_o),
        .refill_done_o          (refill_done_o),
        .core_rsp_valid_o       (core_rsp_valid_o),
        .core_rsp_ready_i       (core_rsp_ready_i),
        .core_rsp_tid_o         (core_rsp_tid_o),
        .core_rsp_sid_o         (core_rsp_sid_o),
        .core_rsp_data_o        (core_rsp_data_o),
        .core_rsp_error_o       (core_rsp_error_o),
        .busy_o                 (busy_o),
        .proto_err_o            (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic garbage_fields();
        mshr_ack_req_id_i      = 6'($urandom);
        mshr_ack_src_id_i      = 3'($urandom);
        mshr_ack_nline_i       = 26'($urandom);
        mshr_ack_word_i        = 3'($urandom);
        mshr_ack_need_rsp_i    = 1'($urandom);
        mshr_ack_is_prefetch_i = 1'($urandom);
    endtask

    // Called at posedge+1 of a cycle where the DUT is idle; returns the same way.
    task automatic run_line(input int way, input int set, input int word, input int need,
                            input int pref, input int gnt_delay, input int err_beat,
                            input int last_beat, input logic [63:0] base, input int rsp_wait,
                            input int pend, input int abort_at);
        logic [25:0] nl;
        logic [5:0]  tid;
        logic [2:0]  sid;
        logic        exp_err;
        logic        exp_rsp;
        nl      = 26'h2A0000 + 26'(set * 16 + way);
        tid     = 6'(set * 3 + word);
        sid     = 3'(word + 1);
        exp_err = 1'b0;
        exp_rsp = (need != 0) && (pref == 0);
        // IDLE: beat presented but not consumed
        mem_rsp_valid_i = 1'b1;
        mem_rsp_id_i    = {2'(way), 4'(set)};
        mem_rsp_data_i  = 64'hDEAD;
        mem_rsp_last_i  = 1'b0;
        mem_rsp_error_i = 1'b0;
        garbage_fields();
        @(negedge clk_i);
        chk("idle_ready", mem_rsp_ready_o, 0);
        chk("idle_ack", mshr_ack_o, 0);
        chk("idle_core_valid", core_rsp_valid_o, 0);
        chk("idle_done", refill_done_o, 0);
        @(posedge clk_i); #1;
        // ACK: the id must already be registered
        mem_rsp_id_i = 6'h3F;
        for (int i = 0; i < gnt_delay; i++) begin
            mshr_ack_gnt_i = 1'b0;
            @(negedge clk_i);
            chk("ack_wait_ack", mshr_ack_o, 0);
            chk("ack_wait_ready", mem_rsp_ready_o, 0);
            chk("ack_wait_busy", busy_o, 1);
            @(posedge clk_i); #1;
        end
        mshr_ack_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("ack_strobe", mshr_ack_o, 1);
        chk("ack_set", mshr_ack_set_o, 64'(set));
        chk("ack_way", mshr_ack_way_o, 64'(way));
        @(posedge clk_i); #1;
        // META: entry fields valid only this cycle
        mshr_ack_gnt_i         = 1'b0;
        mshr_ack_req_id_i      = tid;
        mshr_ack_src_id_i      = sid;
        mshr_ack_nline_i       = nl;
        mshr_ack_word_i        = 3'(word);
        mshr_ack_need_rsp_i    = 1'(need);
        mshr_ack_is_prefetch_i = 1'(pref);
        @(negedge clk_i);
        chk("meta_ack", mshr_ack_o, 0);
        chk("meta_ready", mem_rsp_ready_o, 0);
        @(posedge clk_i); #1;
        garbage_fields();
        for (int k = 0; k < 8; k++) begin
            if (k == abort_at) break;
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = base + 64'(k);
            mem_rsp_error_i = (k == err_beat);
            mem_rsp_last_i  = (k == last_beat);
            if ((k == last_beat) != (k == 7)) exp_proto = 1'b1;
            if (k == err_beat) exp_err = 1'b1;
            @(negedge clk_i);
            chk("beat_ready", mem_rsp_ready_o, 1);
            chk("beat_write", refill_write_o, 1);
            chk("beat_word", refill_word_o, 64'(k));
            chk("beat_data", refill_data_o, base + 64'(k));
            if (k == 0) chk("beat_nline", refill_nline_o, 64'(nl));
            @(posedge clk_i); #1;
        end
        mem_rsp_valid_i = 1'b0;
        mem_rsp_error_i = 1'b0;
        mem_rsp_last_i  = 1'b0;
        if (abort_at < 8) begin
            rst_i     = 1'b1;
            exp_proto = 1'b0;
            @(posedge clk_i); #1;
            rst_i = 1'b0;
            @(negedge clk_i);
            chk("abort_busy", busy_o, 0);
            chk("abort_write", refill_write_o, 0);
            chk("abort_done", refill_done_o, 0);
            chk("abort_core_valid", core_rsp_valid_o, 0);
            chk("abort_proto", proto_err_o, 0);
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("abort_done2", refill_done_o, 0);
            chk("abort_core_valid2", core_rsp_valid_o, 0);
            chk("abort_ack", mshr_ack_o, 0);
            @(posedge clk_i); #1;
            return;
        end
        @(negedge clk_i);
        chk("done_pulse", refill_done_o, 1);
        chk("done_write", refill_write_o, 0);
        chk("done_busy", busy_o, 64'(exp_rsp));
        chk("done_core_valid", core_rsp_valid_o, 64'(exp_rsp));
        chk("done_proto", proto_err_o, 64'(exp_proto));
        if (!exp_rsp) begin
            @(posedge clk_i); #1;
            return;
        end
        chk("rsp_tid", core_rsp_tid_o, 64'(tid));
        chk("rsp_sid", core_rsp_sid_o, 64'(sid));
        chk("rsp_data", core_rsp_data_o, base + 64'(word));
        chk("rsp_error", core_rsp_error_o, 64'(exp_err));
        core_rsp_ready_i = 1'b0;
        if (pend != 0) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_id_i    = 6'h15;
        end
        for (int i = 0; i < rsp_wait; i++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("rsp_hold_valid", core_rsp_valid_o, 1);
            chk("rsp_hold_data", core_rsp_data_o, base + 64'(word));
            chk("rsp_hold_tid", core_rsp_tid_o, 64'(tid));
            chk("rsp_hold_done", refill_done_o, 0);
            chk("rsp_hold_ack", mshr_ack_o, 0);
            chk("rsp_hold_mready", mem_rsp_ready_o, 0);
        end
        core_rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        core_rsp_ready_i = 1'b0;
    endtask

    initial begin
        rst_i                  = 1'b1;
        mem_rsp_valid_i        = 1'b0;
        mem_rsp_id_i           = '0;
        mem_rsp_data_i         = '0;
        mem_rsp_last_i         = 1'b0;
        mem_rsp_error_i        = 1'b0;
        mshr_ack_gnt_i         = 1'b0;
        core_rsp_ready_i       = 1'b0;
        garbage_fields();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", mem_rsp_ready_o, 0);
        chk("rst_ack", mshr_ack_o, 0);
        chk("rst_write", refill_write_o, 0);
        chk("rst_done", refill_done_o, 0);
        chk("rst_core_valid", core_rsp_valid_o, 0);
        chk("rst_proto", proto_err_o, 0);
        chk("rst_word", refill_word_o, 0);
        chk("rst_data", core_rsp_data_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // basic refill, word 3 requested, data = beat index
        run_line(1, 5, 3, 1, 0, 0, 99, 7, 64'h0, 0, 0, 99);
        // grant withheld for 4 cycles
        run_line(2, 9, 0, 1, 0, 4, 99, 7, 64'h100, 0, 0, 99);
        // prefetch: no core response
        run_line(3, 2, 6, 1, 1, 0, 99, 7, 64'h200, 0, 0, 99);
        // core stalls 3 cycles while the next line is pending
        run_line(0, 15, 7, 1, 0, 0, 99, 7, 64'h300, 3, 1, 99);
        // bus error on beat 2, early last marker on beat 5
        run_line(1, 1, 2, 1, 0, 0, 2, 5, 64'h400, 0, 0, 99);
        // no response needed; protocol error stays sticky
        run_line(2, 6, 5, 0, 0, 0, 99, 7, 64'h500, 0, 0, 99);
        // reset after four beats abandons the line
        run_line(3, 12, 1, 1, 0, 0, 99, 7, 64'h600, 0, 0, 4);
        // full refill after the reset
        run_line(1, 5, 3, 1, 0, 0, 99, 7, 64'h0, 0, 0, 99);

        @(negedge clk_i);
        chk("end_busy", busy_o, 0);
        chk("end_proto", proto_err_o, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
